divunit: RTL
============

Name: divunit

Overview:
- Iterative RV32M divide/remainder unit. Sits directly downstream of the register file.
- Consumes the ru1/ru2 operand pair; its result returns to the register file write-data path (RuWrData) once done.
- Covers DIV, DIVU, REM and REMU with radix-2 restoring division, one quotient bit per cycle.
- Start/busy/done handshake so control can stall the monocycle core while it runs.

Parameters:
- XLEN, 32, operand and result width.
- ITERS, XLEN, number of restoring iterations; must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- DivOp  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- A  in  XLEN  dividend (from ru1).
- B  in  XLEN  divisor (from ru2).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result valid from this cycle on.
- result  out  XLEN  quotient or remainder per the latched DivOp.

Behaviour:
- Reset: rst=1 at a rising edge forces IDLE and busy=0, done=0, result=0, internal registers=0.
  - Reset mid-operation aborts the operation with no done pulse.
  - rst has priority over start.
- Clock: one clock only, rising edge. Ports cross to the negedge-write register file only through normal setup; there is no async path.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1 at edge N: latch DivOp, signedness, operand signs and magnitudes (|A|, |B| for signed ops; raw values for unsigned ops).
  - Normal case: go to CALC, count=0.
  - Special cases go straight to DONE at edge N with result loaded:
    - B==0: quotient = all ones; remainder = A.
    - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- CALC, one iteration per edge:
  - rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd shifts left.
  - If rem >= divisor: rem -= divisor and set quotient bit = 1.
  - Subtraction is XLEN+1 bits wide so the borrow is the comparison.
  - After ITERS iterations (edges N+1..N+32), go to FIX.
- FIX (edge N+33):
  - Signed quotient is negated iff sign(A) != sign(B).
  - Signed remainder takes the sign of A.
  - Select quotient or remainder into result; go to DONE.
- DONE: done=1 for exactly one cycle; busy=0.
  - Normal latency: done high in the cycle after edge N+33.
  - Special cases: done high in the cycle after edge N.
  - start in DONE is accepted, giving back-to-back operation. Otherwise go to IDLE.
- busy=1 in CALC and FIX.
  - start while busy is ignored, and operands are not re-sampled.
  - A, B and DivOp may change freely after the start edge.
- result holds its value through IDLE until the next completion or reset. It is never driven with partial results during CALC or FIX.
- Zero dividend needs no special case; the normal path gives 0.

Decomposition:
- Shared package riscv_pkg holds:
  - divop_t enum (DIV, DIVU, REM, REMU) with the encodings above.
  - div_state_t enum.
  - XLEN constant.
  - DIV_OVF_DIVIDEND constant (0x80000000).
- No sub-module; the single-iteration step is a package function div_step(rem, dvd_msb, divisor) returning {ge, new_rem}.

Test Plan:
- DIVU A=100, B=7, start at edge N -> busy=1 from N+1; done pulse after edge N+33; result=14. Same operands with REMU -> result=2.
- DIV A=-20 (0xFFFFFFEC), B=3 -> result=0xFFFFFFFA (-6). REM with the same operands -> result=0xFFFFFFFE (-2), sign follows dividend.
- DIV A=5, B=0 -> done in the cycle after edge N; result=0xFFFFFFFF. REMU A=5, B=0 -> result=5.
- DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000 with 1-cycle latency. REM with the same operands -> result=0.
- DIVU 0xFFFFFFFF/1 started, then start=1 with new operands at edge N+10 -> new request ignored; result=0xFFFFFFFF. Then assert rst at edge N+5 of a fresh operation -> IDLE, result=0, no done pulse.
- Back-to-back: second start asserted during the DONE cycle -> accepted with no idle gap; second done arrives 33 edges later with the correct value.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the divide unit: operand width, operation
// encodings, FSM states and the single restoring-division step.
package riscv_pkg;

  localparam int XLEN = 32;

  // Dividend of the one signed case whose true quotient does not fit in XLEN bits
  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // One restoring iteration. The partial remainder is shifted left with the next
  // dividend bit brought in. The shifted value can need XLEN+1 bits when the divisor
  // is above 2^(XLEN-1), so the trial subtraction is one bit wider again. Its borrow
  // bit is the "remainder < divisor" comparison. Returns {quotient_bit, new_remainder}.
  function automatic logic [XLEN:0] div_step(input logic [XLEN-1:0] rem,
                                             input logic            dvd_msb,
                                             input logic [XLEN-1:0] divisor);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            ge;
    shifted = {rem, dvd_msb};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    ge      = ~diff[XLEN+1];
    return {ge, (ge ? diff[XLEN-1:0] : shifted[XLEN-1:0])};
  endfunction

endpackage

// File: rtl/divunit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit. Radix-2 restoring division produces one
// quotient bit per clock. The division runs on operand magnitudes, and the signs are
// fixed up in a final cycle. Divide-by-zero and signed overflow finish in one cycle.
module divunit #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      DivOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  localparam int CW = $clog2(ITERS);

  div_state_t      state;
  divop_t          op;
  logic            negq;
  logic            negr;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] divisor;
  logic [CW-1:0]   count;

  logic            opsigned;
  logic            asign;
  logic            bsign;
  logic [XLEN-1:0] amag;
  logic [XLEN-1:0] bmag;
  logic            divzero;
  logic            ovf;
  logic [XLEN:0]   step;
  logic [XLEN-1:0] qfix;
  logic [XLEN-1:0] rfix;

  // The even encodings (DIV, REM) are the signed operations.
  assign opsigned = ~DivOp[0];
  assign asign    = opsigned & A[XLEN-1];
  assign bsign    = opsigned & B[XLEN-1];
  assign amag     = asign ? -A : A;
  assign bmag     = bsign ? -B : B;
  assign divzero  = (B == '0);
  assign ovf      = opsigned & (A == DIV_OVF_DIVIDEND) & (B == '1);

  // The dvd register doubles as the quotient accumulator: bits leave at the top
  // as dividend bits and enter at the bottom as quotient bits.
  assign step = div_step(rem, dvd[XLEN-1], divisor);
  assign qfix = negq ? -dvd : dvd;
  assign rfix = negr ? -rem : rem;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // Operation sequencing: accept in IDLE/DONE, iterate, sign-fix, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= DIV;
      negq    <= 1'b0;
      negr    <= 1'b0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      count   <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op      <= divop_t'(DivOp);
            negq    <= asign ^ bsign;
            negr    <= asign;
            rem     <= '0;
            dvd     <= amag;
            divisor <= bmag;
            count   <= '0;
            if (divzero) begin
              result <= DivOp[1] ? A : '1;
              state  <= DONE;
            end else if (ovf) begin
              result <= DivOp[1] ? '0 : DIV_OVF_DIVIDEND;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem   <= step[XLEN-1:0];
          dvd   <= {dvd[XLEN-2:0], step[XLEN]};
          count <= count + 1'b1;
          if (count == CW'(ITERS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= ((op == REM) || (op == REMU)) ? rfix : qfix;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
